// File: rtl/cvt_bb_scheduler.sv
// Basic-block scheduler: scans a dependency table (CVT) round-robin and issues
// each BB whose dependencies have all completed, flagging deadlock after a full fruitless scan.
module cvt_bb_scheduler #(
  parameter int N_BB = 16,
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            cvt_rd_en,
  output logic [ID_W-1:0] cvt_addr,
  input  logic [N_BB-1:0] cvt_rdata,
  output logic            bb_valid,
  output logic [ID_W-1:0] bb_id,
  input  logic            bb_ready,
  input  logic            bb_done,
  output logic [N_BB-1:0] completed,
  output logic            busy,
  output logic            all_done,
  output logic            deadlock
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    EVAL     = 3'd2,
    ISSUE    = 3'd3,
    WAIT     = 3'd4,
    DONE     = 3'd5,
    DEADLOCK = 3'd6
  } state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, ptr_nxt;
  logic [ID_W:0]   scnt, scnt_nxt;
  logic [N_BB-1:0] completed_nxt;
  logic [N_BB-1:0] ptr_onehot;
  logic            entry_ready;

  assign ptr_onehot  = {{(N_BB-1){1'b0}}, 1'b1} << ptr;
  // A self-dependency is never satisfied because completed[ptr] is still clear here.
  assign entry_ready = ((completed & ptr_onehot) == {N_BB{1'b0}}) &&
                       ((cvt_rdata & ~completed) == {N_BB{1'b0}});

  // State, scan pointer, completion mask and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= {ID_W{1'b0}};
      scnt      <= {(ID_W+1){1'b0}};
      completed <= {N_BB{1'b0}};
      cvt_rd_en <= 1'b0;
      cvt_addr  <= {ID_W{1'b0}};
      bb_valid  <= 1'b0;
      bb_id     <= {ID_W{1'b0}};
      busy      <= 1'b0;
      all_done  <= 1'b0;
      deadlock  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      scnt      <= scnt_nxt;
      completed <= completed_nxt;
      cvt_rd_en <= (state_nxt == READ);
      cvt_addr  <= ptr_nxt;
      bb_valid  <= (state_nxt == ISSUE);
      bb_id     <= ptr_nxt;
      busy      <= !((state_nxt == IDLE) || (state_nxt == DONE) || (state_nxt == DEADLOCK));
      all_done  <= (state_nxt == DONE);
      deadlock  <= (state_nxt == DEADLOCK);
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    scnt_nxt      = scnt;
    completed_nxt = completed;
    case (state)
      IDLE, DONE, DEADLOCK: begin
        if (start) begin
          state_nxt     = READ;
          ptr_nxt       = {ID_W{1'b0}};
          scnt_nxt      = {(ID_W+1){1'b0}};
          completed_nxt = {N_BB{1'b0}};
        end else begin
          state_nxt = state;
        end
      end
      READ: state_nxt = EVAL;
      EVAL: begin
        if (entry_ready) begin
          state_nxt = ISSUE;
        end else begin
          ptr_nxt  = ptr + {{(ID_W-1){1'b0}}, 1'b1};
          scnt_nxt = scnt + {{ID_W{1'b0}}, 1'b1};
          if (scnt_nxt == (ID_W+1)'(N_BB)) begin
            state_nxt = DEADLOCK;
          end else begin
            state_nxt = READ;
          end
        end
      end
      ISSUE: begin
        if (bb_ready) begin
          state_nxt = WAIT;
        end else begin
          state_nxt = ISSUE;
        end
      end
      WAIT: begin
        if (bb_done) begin
          completed_nxt = completed | ptr_onehot;
          ptr_nxt       = ptr + {{(ID_W-1){1'b0}}, 1'b1};
          scnt_nxt      = {(ID_W+1){1'b0}};
          if (&completed_nxt) begin
            state_nxt = DONE;
          end else begin
            state_nxt = READ;
          end
        end else begin
          state_nxt = WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cvt_bb_scheduler.sv
// Directed bench for cvt_bb_scheduler: registered CVT memory model, handshake
// tasks and hand-computed issue orders for the nominal, reordered, deadlock and reset cases.
module tb_cvt_bb_scheduler;
  localparam int N_BB = 16;
  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            cvt_rd_en;
  logic [ID_W-1:0] cvt_addr;
  logic [N_BB-1:0] cvt_rdata = '0;
  logic            bb_valid;
  logic [ID_W-1:0] bb_id;
  logic            bb_ready;
  logic            bb_done;
  logic [N_BB-1:0] completed;
  logic            busy;
  logic            all_done;
  logic            deadlock;

  logic [N_BB-1:0] mem [N_BB];
  int n_cmp = 0;
  int n_bad = 0;

  cvt_bb_scheduler #(.N_BB(N_BB), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cvt_rd_en(cvt_rd_en), .cvt_addr(cvt_addr), .cvt_rdata(cvt_rdata),
    .bb_valid(bb_valid), .bb_id(bb_id), .bb_ready(bb_ready), .bb_done(bb_done),
    .completed(completed), .busy(busy), .all_done(all_done), .deadlock(deadlock)
  );

  always #5 clk = ~clk;

  // CVT returns data one cycle after the read strobe
  always @(posedge clk) if (cvt_rd_en) cvt_rdata <= mem[cvt_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, 32'({cvt_rd_en, cvt_addr, bb_valid, bb_id, busy, all_done, deadlock, completed}), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_issue(input int exp_id);
    int k = 0;
    while (!bb_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("issue_seen_%0d", exp_id), 32'(bb_valid), 32'd1);
    chk($sformatf("bb_id_%0d", exp_id), 32'(bb_id), 32'(exp_id));
  endtask

  task automatic finish_bb();
    @(negedge clk);
    @(negedge clk);
    bb_done = 1'b1;
    @(negedge clk);
    bb_done = 1'b0;
  endtask

  initial begin
    int reads;
    int issued;
    int k;
    rst = 1'b1; start = 1'b0; bb_ready = 1'b1; bb_done = 1'b0;
    for (int i = 0; i < N_BB; i++) mem[i] = '0;
    @(negedge clk); @(negedge clk);
    chk_reset_outs("reset_state");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_quiet", 32'({cvt_rd_en, bb_valid, busy}), 32'd0);
    end

    // All-independent table: linear order 0..15, then DONE
    pulse_start();
    chk("read_cycle", 32'({cvt_rd_en, cvt_addr, busy}), 32'b1_0000_1);
    @(negedge clk);
    chk("eval_cycle", 32'({cvt_rd_en, bb_valid, busy}), 32'b001);
    @(negedge clk);
    chk("latency3", 32'(bb_valid), 32'd1);
    for (int i = 0; i < N_BB; i++) begin
      wait_issue(i);
      finish_bb();
    end
    chk("doneA_flags", 32'({all_done, deadlock, busy}), 32'b100);
    chk("doneA_mask", 32'(completed), 32'h0000FFFF);
    repeat (3) @(negedge clk);
    chk("doneA_hold", 32'({all_done, cvt_rd_en, bb_valid}), 32'b100);
    chk("doneA_hold_mask", 32'(completed), 32'h0000FFFF);

    // Entry 0 depends on BB 1: order 1..15 then 0; start from DONE clears the mask
    mem[0] = 16'h0002;
    pulse_start();
    chk("restart_mask", 32'(completed), 32'd0);
    chk("restart_addr", 32'({cvt_rd_en, cvt_addr}), 32'b1_0000);
    for (int i = 1; i <= N_BB; i++) begin
      wait_issue(i % N_BB);
      finish_bb();
    end
    chk("doneB_flags", 32'({all_done, deadlock}), 32'b10);
    chk("doneB_mask", 32'(completed), 32'h0000FFFF);

    // Self-dependency on BB 3: everything else completes, then deadlock after 16 reads
    mem[0] = '0;
    mem[3] = 16'h0008;
    pulse_start();
    for (int i = 0; i < N_BB; i++) begin
      if (i != 3) begin
        wait_issue(i);
        finish_bb();
      end
    end
    reads = 0; issued = 0; k = 0;
    while (!deadlock && k < 100) begin
      if (cvt_rd_en) reads++;
      if (bb_valid) issued++;
      @(negedge clk);
      k++;
    end
    chk("dl_reads", 32'(reads), 32'd16);
    chk("dl_issued", 32'(issued), 32'd0);
    chk("dl_flags", 32'({deadlock, all_done, busy}), 32'b100);
    chk("dl_mask", 32'(completed), 32'h0000FFF7);

    // Backpressure: bb_valid/bb_id stable, stray bb_done and start ignored
    mem[3] = '0;
    bb_ready = 1'b0;
    pulse_start();
    wait_issue(0);
    for (int j = 1; j < 5; j++) begin
      @(negedge clk);
      if (j == 1) bb_done = 1'b1;
      if (j == 2) bb_done = 1'b0;
      chk($sformatf("stall_%0d", j), 32'({bb_valid, bb_id, busy}), 32'b1_0000_1);
    end
    bb_done = 1'b0;
    bb_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", 32'({bb_valid, busy}), 32'b01);
    chk("stray_done_ignored", 32'(completed), 32'd0);
    pulse_start();
    chk("start_in_wait", 32'({cvt_rd_en, bb_valid, busy}), 32'b001);
    chk("start_in_wait_mask", 32'(completed), 32'd0);
    bb_done = 1'b1;
    @(negedge clk);
    bb_done = 1'b0;
    chk("first_done_mask", 32'(completed), 32'd1);
    for (int i = 1; i < 8; i++) begin
      wait_issue(i);
      finish_bb();
    end
    wait_issue(8);
    @(negedge clk);
    chk("wait_mask_ff", 32'(completed), 32'h000000FF);

    // Asynchronous reset mid-WAIT
    #2 rst = 1'b1;
    #1 chk_reset_outs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", 32'({cvt_rd_en, bb_valid, busy}), 32'd0);
    end
    pulse_start();
    chk("post_reset_read", 32'({cvt_rd_en, cvt_addr}), 32'b1_0000);
    wait_issue(0);
    finish_bb();
    chk("post_reset_mask", 32'(completed), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cvt_bb_scheduler.md
CVT_BB_SCHEDULER -- requirements
Module: cvt_bb_scheduler

Interface
REQ-001 Parameter N_BB, default 16, number of basic blocks (BBs) and CVT entries; power of two.
REQ-002 Parameter ID_W, default 4, log2(N_BB); width of BB IDs and CVT addresses.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset is asynchronous and active-high.
REQ-005 start  in  1  begin a scheduling round; accepted only in IDLE, DONE or DEADLOCK.
REQ-006 cvt_rd_en  out  1  CVT read strobe.
REQ-007 cvt_addr  out  ID_W  CVT entry index being read.
REQ-008 cvt_rdata  in  N_BB  dependency bitmap of entry cvt_addr, valid exactly 1 cycle after cvt_rd_en; bit k set = depends on BB k.
REQ-009 bb_valid  out  1  BB issue request to the execution unit.
REQ-010 bb_id  out  ID_W  ID of the BB being issued; stable while bb_valid is high.
REQ-011 bb_ready  in  1  execution unit accepts the issue.
REQ-012 bb_done  in  1  single-cycle pulse: the issued BB has finished.
REQ-013 completed  out  N_BB  completed-BB mask, one bit per BB.
REQ-014 busy  out  1  high in every state except IDLE, DONE and DEADLOCK.
REQ-015 all_done  out  1  high in DONE.
REQ-016 deadlock  out  1  high in DEADLOCK.

Function
REQ-017 FSM states SHALL be IDLE, READ, EVAL, ISSUE, WAIT, DONE and DEADLOCK, with registered pointer ptr (ID_W bits) and scan counter scnt (ID_W+1 bits).
REQ-018 IDLE/DONE/DEADLOCK + start -> READ; on this transition: completed <= 0, ptr <= 0, scnt <= 0.
REQ-019 READ: cvt_rd_en=1 and cvt_addr=ptr for exactly one cycle -> EVAL.
REQ-020 EVAL: sample cvt_rdata; entry is ready iff completed[ptr]==0 and (cvt_rdata & ~completed)==0.
REQ-021 EVAL, entry ready -> ISSUE.
REQ-022 EVAL, entry not ready: ptr <= ptr+1 (modulo N_BB, 15->0), scnt <= scnt+1; if scnt+1==N_BB -> DEADLOCK, else -> READ.
REQ-023 ISSUE: bb_valid=1, bb_id=ptr; hold until bb_ready=1; on that cycle -> WAIT. Issue handshake completes on the same cycle as bb_valid&&bb_ready.
REQ-024 WAIT: on bb_done: set completed[ptr], ptr <= ptr+1 (wrap), scnt <= 0; if completed becomes all ones -> DONE, else -> READ.
REQ-025 Scan order SHALL be round-robin starting from the entry after the last completed BB; after any completion, the scan restarts its full-table budget.
REQ-026 A self-dependency (bit ptr set in entry ptr) SHALL never be satisfied.
REQ-027 bb_done outside WAIT, and bb_ready outside ISSUE, SHALL be ignored.
REQ-028 start in READ, EVAL, ISSUE or WAIT SHALL be ignored.
REQ-029 cvt_rd_en SHALL be 0 and bb_valid SHALL be 0 in every state not named for them in REQ-019 and REQ-023.
REQ-030 Minimum latency from start to first bb_valid SHALL be 3 cycles (READ, EVAL, ISSUE).
REQ-031 DONE and DEADLOCK SHALL hold, with outputs stable, until start.

Reset
REQ-032 rst SHALL force, asynchronously at any time including mid-issue: state=IDLE, ptr=0, scnt=0, completed=0, cvt_rd_en=0, cvt_addr=0, bb_valid=0, bb_id=0, busy=0, all_done=0, deadlock=0.
REQ-033 After rst deasserts, no read or issue SHALL occur before start.

Verification
REQ-034 All bitmaps 0, start, bb_ready tied 1, bb_done 2 cycles after each issue -> bb_id sequence 0..15, then all_done=1 and completed=16'hFFFF.
REQ-035 Entry 0 = 16'h0002, others 0 -> first issued bb_id=1, then 2..15, then 0, then DONE.
REQ-036 Entry 3 = 16'h0008 (self-dependency), others 0 -> BBs other than 3 complete, then 16 reads without issue -> deadlock=1, completed=16'hFFF7.
REQ-037 bb_ready held 0 for 5 cycles in ISSUE -> bb_valid and bb_id stable all 5 cycles; a bb_done pulse during those cycles is ignored; WAIT is entered on the ready cycle.
REQ-038 rst asserted during WAIT with completed=16'h00FF -> immediately all outputs at reset values; a later start restarts at bb_id=0.
REQ-039 start pulsed in WAIT -> no effect; start in DONE -> completed cleared and a new round begins at ptr 0.
